// File: rtl/bcd_7seg_scan_driver.sv
// Scans three BCD digits plus a blank onto a 4-digit common-anode 7-segment display; new values are applied only at frame boundaries.
// Latency: seg/an lag the scan index by 1 clk; a load becomes visible at the first frame boundary after it. No backpressure: load is always accepted, last load wins.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros of the displayed value.
module bcd_7seg_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       pending
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] BLANK = 7'h7F;

    logic [CW-1:0] r_div_cnt;
    logic [1:0]    r_idx;
    logic [11:0]   r_pend;
    logic [11:0]   r_disp;
    logic          r_pending;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic          w_tick;
    logic          w_frame;
    logic          w_blank_h;
    logic          w_blank_t;
    logic [6:0]    w_seg_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign w_tick  = (r_div_cnt == CW'(REFRESH_DIV - 1));
    assign w_frame = w_tick && (r_idx == 2'd3);

`ifdef LEADING_ZERO_BLANK_EN
    // Blanking looks at the shown value so the display matches what is lit.
    assign w_blank_h = (r_disp[11:8] == 4'd0);
    assign w_blank_t = w_blank_h && (r_disp[7:4] == 4'd0);
`else
    assign w_blank_h = 1'b0;
    assign w_blank_t = 1'b0;
`endif

    always_comb begin
        w_seg_nxt = BLANK;
        case (r_idx)
            2'd0:    w_seg_nxt = f_decode(r_disp[3:0]);
            2'd1:    w_seg_nxt = w_blank_t ? BLANK : f_decode(r_disp[7:4]);
            2'd2:    w_seg_nxt = w_blank_h ? BLANK : f_decode(r_disp[11:8]);
            default: w_seg_nxt = BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_idx     <= 2'd0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick)
                r_idx <= r_idx + 2'd1;
        end
    end

    // A load coincident with a frame still arms pending, so the new value waits a full frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend    <= '0;
            r_disp    <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_frame && r_pending)
                r_disp <= r_pend;
            if (load) begin
                r_pend    <= {hundreds, tens, ones};
                r_pending <= 1'b1;
            end else if (w_frame) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= BLANK;
            r_an  <= 4'hF;
        end else begin
            r_seg <= w_seg_nxt;
            r_an  <= ~(4'b0001 << r_idx);
        end
    end

    assign seg     = r_seg;
    assign an      = r_an;
    assign dp      = 1'b1;
    assign pending = r_pending;
endmodule
